// File: rtl/coord_stream_reader.sv
// coord_stream_reader: sweeps the shared X/Y coordinate memory read port over
// entries 0..arr_size-1. Each on-screen (x, y) pair is presented as a
// valid/ready point stream. Off-screen pairs are dropped and counted.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   start, arr_size    begin a sweep of arr_size entries (honoured only when idle)
//   rd_addr            read address shared by the X and Y memories
//   x_rd_data/y_rd_data memory read data, valid one cycle after rd_addr
//   pt_valid/pt_ready  point stream handshake; pt_x/pt_y carry the point
//   busy, done         sweep in progress / one-cycle completion pulse
//   drop_cnt           clipped points in the current or last sweep
module coord_stream_reader #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        arr_size,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] x_rd_data,
  input  logic [DATA_W-1:0] y_rd_data,
  output logic              pt_valid,
  input  logic              pt_ready,
  output logic [9:0]        pt_x,
  output logic [8:0]        pt_y,
  output logic              busy,
  output logic              done,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [2:0] {IDLE, READ, LATCH, OUT, DONE} state_t;

  state_t            state, state_n;
  logic [7:0]        idx, idx_n;
  logic [7:0]        size_q, size_n;
  logic [ADDR_W-1:0] rd_addr_n;
  logic              pt_valid_n, busy_n, done_n;
  logic [9:0]        pt_x_n;
  logic [8:0]        pt_y_n;
  logic [7:0]        drop_n;
  logic              advance;
  logic              x_ok, y_ok;

  // Signed range check: a clear sign bit plus an unsigned upper bound.
  assign x_ok = !x_rd_data[DATA_W-1] && (x_rd_data < DATA_W'(SCREEN_W));
  assign y_ok = !y_rd_data[DATA_W-1] && (y_rd_data < DATA_W'(SCREEN_H));

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      size_q   <= '0;
      rd_addr  <= '0;
      pt_valid <= 1'b0;
      pt_x     <= '0;
      pt_y     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      size_q   <= size_n;
      rd_addr  <= rd_addr_n;
      pt_valid <= pt_valid_n;
      pt_x     <= pt_x_n;
      pt_y     <= pt_y_n;
      busy     <= busy_n;
      done     <= done_n;
      drop_cnt <= drop_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    size_n     = size_q;
    rd_addr_n  = rd_addr;
    pt_valid_n = pt_valid;
    pt_x_n     = pt_x;
    pt_y_n     = pt_y;
    busy_n     = busy;
    done_n     = 1'b0;
    drop_n     = drop_cnt;
    advance    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          size_n = arr_size;
          idx_n  = '0;
          drop_n = '0;
          busy_n = 1'b1;
          if (arr_size == 8'd0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n   = READ;
            rd_addr_n = '0;
          end
        end
      end
      READ: state_n = LATCH;
      LATCH: begin
        if (x_ok && y_ok) begin
          pt_x_n     = x_rd_data[9:0];
          pt_y_n     = y_rd_data[8:0];
          pt_valid_n = 1'b1;
          state_n    = OUT;
        end else begin
          if (drop_cnt != 8'hFF) drop_n = drop_cnt + 8'd1;
          advance = 1'b1;
        end
      end
      OUT: begin
        if (pt_ready) begin
          pt_valid_n = 1'b0;
          advance    = 1'b1;
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Step to the next entry or finish; idx never passes size_q-1.
    if (advance) begin
      if (idx == size_q - 8'd1) begin
        state_n = DONE;
        done_n  = 1'b1;
      end else begin
        idx_n     = idx + 8'd1;
        rd_addr_n = ADDR_W'(idx + 8'd1);
        state_n   = READ;
      end
    end
  end

endmodule

// File: tb/tb_coord_stream_reader.sv
// Bench for coord_stream_reader: directed sweeps plus randomized coordinate
// sweeps against a reference model that derives the expected point list,
// drop count and handshake/done cycle numbers from per-entry cycle costs.
module tb_coord_stream_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  arr_size;
  logic [7:0]  rd_addr;
  logic [31:0] x_rd_data, y_rd_data;
  logic        pt_valid, pt_ready;
  logic [9:0]  pt_x;
  logic [8:0]  pt_y;
  logic        busy, done;
  logic [7:0]  drop_cnt;

  logic [31:0] xmem [256];
  logic [31:0] ymem [256];

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {int x; int y; int cyc;} pt_t;

  coord_stream_reader dut (
    .clk(clk), .reset(reset), .start(start), .arr_size(arr_size),
    .rd_addr(rd_addr), .x_rd_data(x_rd_data), .y_rd_data(y_rd_data),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y),
    .busy(busy), .done(done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory pair sharing one address.
  always @(posedge clk) begin
    x_rd_data <= xmem[rd_addr];
    y_rd_data <= ymem[rd_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one sweep. stall_pt: index of emitted point held off for 5 cycles
  // (-1 for none). inject: pulse start with arr_size=1 mid-sweep.
  task automatic sweep(input int size, input int ready_pct, input int stall_pt, input bit inject);
    pt_t q[$];
    pt_t e;
    int  drops = 0;
    int  t = 1;
    int  k = 0;
    int  nout = 0;
    int  stall_left = 5;
    int  done_cyc = -1;
    bit  pv = 1'b0, pr = 1'b0;
    int  px = 0, py = 0;
    int  xs, ys;
    // Reference: on-screen entries cost 3 cycles (+stall), clipped ones 2.
    for (int i = 0; i < size; i++) begin
      xs = $signed(xmem[i]);
      ys = $signed(ymem[i]);
      if (xs >= 0 && xs < 640 && ys >= 0 && ys < 480) begin
        e.x = xs; e.y = ys; e.cyc = t + 2 + ((k == stall_pt) ? 5 : 0);
        q.push_back(e);
        t += 3 + ((k == stall_pt) ? 5 : 0);
        k++;
      end else begin
        drops = (drops < 255) ? drops + 1 : 255;
        t += 2;
      end
    end
    arr_size = 8'(size);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 4000; cyc++) begin
      if (cyc == 1 && size > 0) chk("rd_addr_first", int'(rd_addr), 0);
      if (inject && cyc == 4) begin start = 1'b1; arr_size = 8'd1; end
      else start = 1'b0;
      if (pt_valid && nout == stall_pt && stall_left > 0) begin
        pt_ready = 1'b0;
        stall_left--;
      end else begin
        pt_ready = ($urandom_range(99) < ready_pct);
      end
      if (pv && !pr) begin
        chk("hold_valid", int'(pt_valid), 1);
        chk("hold_x", int'(pt_x), px);
        chk("hold_y", int'(pt_y), py);
      end
      if (done) begin done_cyc = cyc; break; end
      chk("busy_during", int'(busy), 1);
      if (pt_valid && pt_ready) begin
        if (q.size() == 0) chk("extra_point", 1, 0);
        else begin
          e = q.pop_front();
          chk("pt_x", int'(pt_x), e.x);
          chk("pt_y", int'(pt_y), e.y);
          if (ready_pct >= 100) chk("pt_cycle", cyc, e.cyc);
        end
        nout++;
      end
      pv = pt_valid; pr = pt_ready; px = int'(pt_x); py = int'(pt_y);
      tick();
    end
    start = 1'b0;
    chk("done_seen", int'(done_cyc > 0), 1);
    if (ready_pct >= 100) chk("done_cycle", done_cyc, t);
    chk("missing_points", q.size(), 0);
    chk("drop_cnt", int'(drop_cnt), drops);
    chk("busy_at_done", int'(busy), 1);
    chk("valid_at_done", int'(pt_valid), 0);
    pt_ready = 1'b0;
    tick();
    chk("done_pulse_1cyc", int'(done), 0);
    chk("busy_after", int'(busy), 0);
  endtask

  initial begin
    int a0;
    bit saw_done;
    reset = 1'b1; start = 1'b0; arr_size = 8'd0; pt_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin xmem[i] = '0; ymem[i] = '0; end
    tick(); tick();
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_pt_valid", int'(pt_valid), 0);
    chk("rst_pt_x", int'(pt_x), 0);
    chk("rst_pt_y", int'(pt_y), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    reset = 1'b0;
    tick();

    // Three on-screen points, ready held high.
    xmem[0] = 10; xmem[1] = 20; xmem[2] = 30;
    ymem[0] = 5;  ymem[1] = 6;  ymem[2] = 7;
    sweep(3, 100, -1, 1'b0);

    // Boundary clipping: only (639,479) survives.
    xmem[0] = 32'hFFFF_FFFF; xmem[1] = 640; xmem[2] = 639;
    ymem[0] = 0;             ymem[1] = 0;   ymem[2] = 479;
    sweep(3, 100, -1, 1'b0);

    // Empty sweep: done next cycle, address untouched.
    a0 = int'(rd_addr);
    sweep(0, 100, -1, 1'b0);
    chk("rd_addr_unchanged", int'(rd_addr), a0);

    // Backpressure on the second point.
    xmem[0] = 10; xmem[1] = 20; xmem[2] = 30;
    ymem[0] = 5;  ymem[1] = 6;  ymem[2] = 7;
    sweep(3, 100, 1, 1'b0);

    // Mid-sweep start with a new size is ignored.
    sweep(3, 100, -1, 1'b1);

    // Reset while a point waits in OUT.
    arr_size = 8'd3; start = 1'b1; pt_ready = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("pre_reset_valid", int'(pt_valid), 1);
    reset = 1'b1;
    tick();
    chk("abort_valid", int'(pt_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", int'(saw_done), 0);
    sweep(3, 100, -1, 1'b0);

    // Randomized coordinates, mixed on/off screen, random backpressure.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) begin
        xmem[i] = 32'($signed($urandom_range(900)) - 100);
        ymem[i] = 32'($signed($urandom_range(700)) - 100);
      end
      if (r == 3) sweep(255, 100, -1, 1'b0);
      else sweep(int'($urandom_range(60, 1)), 60, -1, 1'b0);
    end

    // Full-size sweep where every entry is clipped.
    for (int i = 0; i < 256; i++) xmem[i] = 32'h8000_0000;
    sweep(255, 100, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
